// File: rtl/base_shift_pkg.sv
// base_shift_pkg: shared types for the pipelined barrel shifter.
// Optional overflow flag is enabled by BASE_SHIFT_PIPE_OVF_EN.
package base_shift_pkg;

  typedef enum logic [1:0] {
    SHL = 2'd0,
    SHR = 2'd1,
    SRA = 2'd2,
    ROL = 2'd3
  } mode_t;

  function automatic logic fill_bit(mode_t mode, logic msb);
    return (mode == SRA) ? msb : 1'b0;
  endfunction

endpackage

// File: rtl/base_shift_pipe_if.sv
// base_shift_pipe request/response handshake interfaces.
// o_ovf exists only when BASE_SHIFT_PIPE_OVF_EN is defined.
interface base_shift_req_if #(
  parameter int width = 32,
  parameter int tag_width = 1
);
  import base_shift_pkg::*;
  localparam int swidth = $clog2(width);

  logic                 i_v;
  logic                 i_r;
  mode_t                i_mode;
  logic [swidth-1:0]    i_samt;
  logic [0:width-1]     i_d;
  logic [0:tag_width-1] i_tag;

  modport master (
    output i_v, i_mode, i_samt, i_d, i_tag,
    input  i_r
  );
  modport slave (
    input  i_v, i_mode, i_samt, i_d, i_tag,
    output i_r
  );
endinterface

interface base_shift_rsp_if #(
  parameter int width = 32,
  parameter int tag_width = 1
);
  logic                 o_v;
  logic                 o_r;
  logic [0:width-1]     o_d;
  logic [0:tag_width-1] o_tag;
`ifdef BASE_SHIFT_PIPE_OVF_EN
  logic                 o_ovf;

  modport master (
    output o_v, o_d, o_tag, o_ovf,
    input  o_r
  );
  modport slave (
    input  o_v, o_d, o_tag, o_ovf,
    output o_r
  );
`else
  modport master (
    output o_v, o_d, o_tag,
    input  o_r
  );
  modport slave (
    input  o_v, o_d, o_tag,
    output o_r
  );
`endif
endinterface

// File: rtl/base_shift_stage.sv
// base_shift_stage: one registered stage resolving amount bits lo..hi.
// Overflow accumulation is present only with BASE_SHIFT_PIPE_OVF_EN.
module base_shift_stage
  import base_shift_pkg::*;
#(
  parameter int width = 32,
  parameter int swidth = 5,
  parameter int tag_width = 1,
  parameter int lo = 0,
  parameter int hi = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 src_v,
  output logic                 src_r,
  input  mode_t                src_mode,
  input  logic [swidth-1:0]    src_samt,
  input  logic [width-1:0]     src_d,
  input  logic [tag_width-1:0] src_tag,
`ifdef BASE_SHIFT_PIPE_OVF_EN
  input  logic                 src_ovf,
  output logic                 q_ovf,
`endif
  output logic                 q_v,
  input  logic                 dst_r,
  output mode_t                q_mode,
  output logic [swidth-1:0]    q_samt,
  output logic [width-1:0]     q_d,
  output logic [tag_width-1:0] q_tag
);

  localparam logic [width-1:0] ones = '1;

  int                 sh;
  logic               fill;
  logic [width-1:0]   nd;
  logic [2*width-1:0] rot;

  // Shift distance for this stage; may exceed width, which
  // naturally yields zero/sign fill and is reduced mod width for ROL.
  always_comb begin
    sh = 0;
    for (int i = lo; i <= hi; i++) begin
      if (src_samt[i]) sh = sh + (1 << i);
    end
  end

  always_comb begin
    fill = fill_bit(src_mode, src_d[width-1]);
    nd   = src_d;
    rot  = '0;
    unique case (1'b1)
      (src_mode == SHL): nd = src_d << sh;
      (src_mode == SHR): nd = src_d >> sh;
      (src_mode == SRA):
        nd = (src_d >> sh) | (~(ones >> sh) & {width{fill}});
      (src_mode == ROL): begin
        rot = {src_d, src_d} << (sh % width);
        nd  = rot[2*width-1 -: width];
      end
      default: nd = src_d;
    endcase
  end

`ifdef BASE_SHIFT_PIPE_OVF_EN
  logic [width-1:0] mask;
  logic             hit;

  always_comb begin
    mask = '0;
    unique case (1'b1)
      (src_mode == SHL): mask = ~(ones >> sh);
      (src_mode == SHR),
      (src_mode == SRA): mask = ~(ones << sh);
      default: mask = '0;
    endcase
    hit = |((src_d ^ {width{fill}}) & mask);
  end
`endif

  assign src_r = ~q_v | dst_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_v    <= 1'b0;
      q_mode <= SHL;
      q_samt <= '0;
      q_d    <= '0;
      q_tag  <= '0;
`ifdef BASE_SHIFT_PIPE_OVF_EN
      q_ovf  <= 1'b0;
`endif
    end else if (src_r) begin
      q_v <= src_v;
      if (src_v) begin
        q_mode <= src_mode;
        q_samt <= src_samt;
        q_d    <= nd;
        q_tag  <= src_tag;
`ifdef BASE_SHIFT_PIPE_OVF_EN
        q_ovf  <= src_ovf | hit;
`endif
      end
    end
  end

endmodule

// File: rtl/base_shift_pipe.sv
// base_shift_pipe: pipelined barrel shifter with valid/ready on both sides.
// Define BASE_SHIFT_PIPE_OVF_EN to add the o_ovf result flag.
module base_shift_pipe
  import base_shift_pkg::*;
#(
  parameter int width = 32,
  parameter int stages = 2,
  parameter int tag_width = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  base_shift_req_if.slave  req,
  base_shift_rsp_if.master rsp
);

  localparam int swidth = $clog2(width);
  localparam int per = (swidth + stages - 1) / stages;

  logic                 v_c    [0:stages];
  logic                 r_c    [0:stages];
  mode_t                mode_c [0:stages];
  logic [swidth-1:0]    samt_c [0:stages];
  logic [width-1:0]     d_c    [0:stages];
  logic [tag_width-1:0] tag_c  [0:stages];

  // Index 0 of the port vectors is the MSB, so plain value copies
  // keep bit significance intact.
  assign v_c[0]    = req.i_v;
  assign mode_c[0] = req.i_mode;
  assign samt_c[0] = req.i_samt;
  assign d_c[0]    = req.i_d;
  assign tag_c[0]  = req.i_tag;
  assign req.i_r   = r_c[0];

  assign r_c[stages] = rsp.o_r;
  assign rsp.o_v     = v_c[stages];
  assign rsp.o_d     = d_c[stages];
  assign rsp.o_tag   = tag_c[stages];

`ifdef BASE_SHIFT_PIPE_OVF_EN
  logic ovf_c [0:stages];
  assign ovf_c[0]  = 1'b0;
  assign rsp.o_ovf = ovf_c[stages];
`endif

  for (genvar k = 0; k < stages; k++) begin : g_stage
    localparam int lo = k * per;
    localparam int hr = (k + 1) * per - 1;
    localparam int hi = (hr > swidth - 1) ? swidth - 1 : hr;

    base_shift_stage #(
      .width     (width),
      .swidth    (swidth),
      .tag_width (tag_width),
      .lo        (lo),
      .hi        (hi)
    ) u_stage (
      .clk      (clk),
      .reset_n  (reset_n),
      .src_v    (v_c[k]),
      .src_r    (r_c[k]),
      .src_mode (mode_c[k]),
      .src_samt (samt_c[k]),
      .src_d    (d_c[k]),
      .src_tag  (tag_c[k]),
`ifdef BASE_SHIFT_PIPE_OVF_EN
      .src_ovf  (ovf_c[k]),
      .q_ovf    (ovf_c[k+1]),
`endif
      .q_v      (v_c[k+1]),
      .dst_r    (r_c[k+1]),
      .q_mode   (mode_c[k+1]),
      .q_samt   (samt_c[k+1]),
      .q_d      (d_c[k+1]),
      .q_tag    (tag_c[k+1])
    );
  end

endmodule

// File: tb/tb_base_shift_pipe.sv
// tb_base_shift_pipe: scoreboard bench for base_shift_pipe (width 8 and 6).
// Overflow vectors run only when BASE_SHIFT_PIPE_OVF_EN is defined.
module tb_base_shift_pipe;
  import base_shift_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int acc = 0;
  int base;

  typedef struct {
    logic [7:0] d;
    logic [3:0] tag;
    logic       ovf;
    bit         chk_ovf;
  } exp_t;

  typedef struct {
    mode_t      mode;
    logic [2:0] samt;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t vecs[14];

  mode_t      rm;
  logic [2:0] rs;
  logic [7:0] rd;

  base_shift_req_if #(.width(8), .tag_width(4)) req8();
  base_shift_rsp_if #(.width(8), .tag_width(4)) rsp8();
  base_shift_req_if #(.width(6), .tag_width(4)) req6();
  base_shift_rsp_if #(.width(6), .tag_width(4)) rsp6();

  base_shift_pipe #(.width(8), .stages(3), .tag_width(4)) dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req8),
    .rsp     (rsp8)
  );

  base_shift_pipe #(.width(6), .stages(3), .tag_width(4)) dut6 (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req6),
    .rsp     (rsp6)
  );

  // Bitwise reference; index 0 is the MSB as on the DUT ports.
  function automatic logic [7:0] model(int w, mode_t m, int s, logic [7:0] d);
    logic b [0:7];
    logic o [0:7];
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      b[i] = 1'b0;
      o[i] = 1'b0;
    end
    for (int i = 0; i < w; i++) b[i] = d[w-1-i];
    for (int i = 0; i < w; i++) begin
      case (m)
        SHL: o[i] = (i + s < w) ? b[i+s] : 1'b0;
        SHR: o[i] = (i >= s) ? b[i-s] : 1'b0;
        SRA: o[i] = (i >= s) ? b[i-s] : b[0];
        default: o[i] = b[(i+s)%w];
      endcase
    end
    r = '0;
    for (int i = 0; i < w; i++) r[w-1-i] = o[i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s got=%0h want=%0h", name, got, want);
  endtask

  always @(posedge clk)
    if (reset_n && req8.i_v && req8.i_r) acc++;

  always @(negedge clk) begin
    if (reset_n && rsp8.o_v && rsp8.o_r) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL extra_output got d=%h tag=%h want none",
                 rsp8.o_d, rsp8.o_tag);
      end else begin
        e = sb.pop_front();
        check("out_d", 32'(rsp8.o_d), 32'(e.d));
        check("out_tag", 32'(rsp8.o_tag), 32'(e.tag));
`ifdef BASE_SHIFT_PIPE_OVF_EN
        if (e.chk_ovf) check("out_ovf", 32'(rsp8.o_ovf), 32'(e.ovf));
`endif
      end
    end
  end

  task automatic send(input mode_t m, input logic [2:0] s,
                      input logic [7:0] d, input logic [3:0] t,
                      input logic [7:0] want, input logic wo = 1'b0,
                      input bit co = 1'b0);
    bit ok = 1'b0;
    sb.push_back('{want, t, wo, co});
    req8.i_v    = 1'b1;
    req8.i_mode = m;
    req8.i_samt = s;
    req8.i_d    = d;
    req8.i_tag  = t;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      ok = req8.i_r;
      @(posedge clk);
    end
    if (!ok) begin
      checks++;
      $display("FAIL accept_timeout got i_r=0 want i_r=1");
    end
    #1 req8.i_v = 1'b0;
  endtask

  task automatic latency(input int want);
    bit seen = 1'b0;
    int lat = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk);
      seen = req8.i_v && req8.i_r;
    end
    for (int n = 1; n <= 10 && lat == 0; n++) begin
      @(negedge clk);
      if (rsp8.o_v) lat = n;
    end
    check("latency", 32'(lat), 32'(want));
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
    check("drain_left", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic send6(input string name, input mode_t m,
                       input logic [2:0] s, input logic [5:0] d,
                       input logic [5:0] want);
    bit ok = 1'b0;
    bit seen = 1'b0;
    req6.i_v    = 1'b1;
    req6.i_mode = m;
    req6.i_samt = s;
    req6.i_d    = d;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = req6.i_r;
      @(posedge clk);
    end
    #1 req6.i_v = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = rsp6.o_v;
    end
    if (!seen) begin
      checks++;
      $display("FAIL %s got no o_v want o_v=1", name);
    end else begin
      check(name, 32'(rsp6.o_d), 32'(want));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset_n     = 1'b1;
    req8.i_v    = 1'b0;
    req8.i_mode = SHL;
    req8.i_samt = '0;
    req8.i_d    = '0;
    req8.i_tag  = '0;
    rsp8.o_r    = 1'b1;
    req6.i_v    = 1'b0;
    req6.i_mode = SHL;
    req6.i_samt = '0;
    req6.i_d    = '0;
    req6.i_tag  = '0;
    rsp6.o_r    = 1'b1;

    vecs[0]  = '{SHL, 3'd3, 8'h01, 8'h08};
    vecs[1]  = '{SRA, 3'd3, 8'h80, 8'hF0};
    vecs[2]  = '{SHR, 3'd7, 8'h80, 8'h01};
    vecs[3]  = '{ROL, 3'd1, 8'h81, 8'h03};
    vecs[4]  = '{SHL, 3'd0, 8'hA5, 8'hA5};
    vecs[5]  = '{SHR, 3'd0, 8'hA5, 8'hA5};
    vecs[6]  = '{SRA, 3'd0, 8'hA5, 8'hA5};
    vecs[7]  = '{ROL, 3'd0, 8'hA5, 8'hA5};
    vecs[8]  = '{SHL, 3'd4, 8'hF3, 8'h30};
    vecs[9]  = '{SHR, 3'd4, 8'hF3, 8'h0F};
    vecs[10] = '{SRA, 3'd4, 8'hF3, 8'hFF};
    vecs[11] = '{SRA, 3'd2, 8'h73, 8'h1C};
    vecs[12] = '{ROL, 3'd5, 8'h96, 8'hD2};
    vecs[13] = '{SHL, 3'd7, 8'hFF, 8'h80};

    #1 reset_n = 1'b0;
    #2;
    check("rst_o_v", 32'(rsp8.o_v), 32'd0);
    check("rst_i_r", 32'(req8.i_r), 32'd1);
    check("rst_o_d", 32'(rsp8.o_d), 32'd0);
    check("rst_o_tag", 32'(rsp8.o_tag), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    fork
      send(SHL, 3'd3, 8'h01, 4'h5, 8'h08);
      latency(3);
    join
    drain();

    foreach (vecs[i])
      send(vecs[i].mode, vecs[i].samt, vecs[i].d, 4'(i), vecs[i].exp);
    drain();

    fork
      for (int i = 0; i < 40; i++) begin
        rm = mode_t'($urandom_range(0, 3));
        rs = 3'($urandom_range(0, 7));
        rd = 8'($urandom);
        send(rm, rs, rd, 4'(i), model(8, rm, int'(rs), rd));
      end
      begin
        repeat (80) begin
          @(posedge clk);
          #1 rsp8.o_r = 1'($urandom_range(0, 1));
        end
        rsp8.o_r = 1'b1;
      end
    join
    rsp8.o_r = 1'b1;
    drain();

    rsp8.o_r = 1'b0;
    base = acc;
    fork
      for (int i = 0; i < 5; i++)
        send(SHL, 3'(i), 8'h11, 4'(8 + i), model(8, SHL, i, 8'h11));
      begin
        repeat (8) @(negedge clk);
        check("bp_accepts", 32'(acc - base), 32'd3);
        check("bp_i_r", 32'(req8.i_r), 32'd0);
        check("bp_o_v", 32'(rsp8.o_v), 32'd1);
        for (int j = 0; j < 3; j++) begin
          check("bp_hold_d", 32'(rsp8.o_d), 32'h11);
          check("bp_hold_tag", 32'(rsp8.o_tag), 32'h8);
          @(negedge clk);
        end
        @(posedge clk);
        #1 rsp8.o_r = 1'b1;
      end
    join
    drain();

    rsp8.o_r = 1'b0;
    send(SRA, 3'd1, 8'h80, 4'hA, 8'hC0);
    send(ROL, 3'd2, 8'h40, 4'hB, 8'h01);
    @(posedge clk);
    @(posedge clk);
    #3;
    check("pre_rst_o_v", 32'(rsp8.o_v), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst2_o_v", 32'(rsp8.o_v), 32'd0);
    check("rst2_i_r", 32'(req8.i_r), 32'd1);
    check("rst2_o_d", 32'(rsp8.o_d), 32'd0);
    sb.delete();
    rsp8.o_r = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    fork
      send(SHR, 3'd5, 8'hE0, 4'h3, 8'h07);
      latency(3);
    join
    drain();

    send6("w6_shl_ovr", SHL, 3'd7, 6'b111111, 6'b000000);
    send6("w6_rol_ovr", ROL, 3'd7, 6'b100000, 6'b000001);
    send6("w6_sra_ovr", SRA, 3'd7, 6'b100000, 6'b111111);
    send6("w6_shr_full", SHR, 3'd6, 6'b111111, 6'b000000);
    send6("w6_rol_wrap", ROL, 3'd6, 6'b100000, 6'b100000);
    send6("w6_shl_2", SHL, 3'd2, 6'b000011, 6'b001100);

`ifdef BASE_SHIFT_PIPE_OVF_EN
    send(SHL, 3'd1, 8'h81, 4'h1, 8'h02, 1'b1, 1'b1);
    send(SHL, 3'd1, 8'h01, 4'h2, 8'h02, 1'b0, 1'b1);
    send(SRA, 3'd1, 8'h71, 4'h3, 8'h38, 1'b1, 1'b1);
    send(SRA, 3'd2, 8'hF0, 4'h4, 8'hFC, 1'b1, 1'b1);
    send(SHR, 3'd4, 8'hF0, 4'h5, 8'h0F, 1'b0, 1'b1);
    send(ROL, 3'd3, 8'hFF, 4'h6, 8'hFF, 1'b0, 1'b1);
    drain();
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
